// File: rtl/ahb_ram_responder_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and the data RAM responder.
// hready is driven by the interconnect side, so it sits with the master outputs.
interface ahb_ram_responder_if;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_ram_responder.sv
// AHB-Lite responder for the data RAM region: programmable wait states, little-endian
// byte-lane writes, full-word reads and the two-cycle ERROR response for illegal accesses.
module ahb_ram_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [7:0]  BASE        = 8'hB0,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic                 hclk,
   input logic                 hreset,
   ahb_ram_responder_if.slave  bus
);

   localparam logic [2:0] WaitLoad = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

   typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

   state_e                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            off_q;
   logic [2:0]            size_q;
   logic                  write_q;
   logic                  err_q;

   logic                  accept_ok;
   logic                  capture;
   logic                  addr_err;
   logic                  commit;
   logic [3:0]            lane_en;
   logic                  unused_hprot;

   logic [31:0] mem [2**ADDR_WIDTH];

   assign unused_hprot = ^bus.hprot;

   // A new address phase can only be accepted while this slave is driving hready high.
   assign accept_ok = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
   assign capture   = bus.hsel && bus.hready && bus.htrans[1] && accept_ok;

   always_comb begin
      addr_err = 1'b0;
      if (bus.haddr[31:24] != BASE) addr_err = 1'b1;
      if ((bus.haddr[23:0] >> (ADDR_WIDTH + 2)) != 24'd0) addr_err = 1'b1;
      if (bus.hsize > 3'b010) addr_err = 1'b1;
      if (bus.hsize == 3'b001 && bus.haddr[0]) addr_err = 1'b1;
      if (bus.hsize == 3'b010 && bus.haddr[1:0] != 2'b00) addr_err = 1'b1;
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         addr_q  <= '0;
         off_q   <= 2'b00;
         size_q  <= 3'b000;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (capture) begin
         addr_q  <= bus.haddr[ADDR_WIDTH+1:2];
         off_q   <= bus.haddr[1:0];
         size_q  <= bus.hsize;
         write_q <= bus.hwrite;
         err_q   <= addr_err;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StData, StErr2: begin
            if (capture) begin
               if (addr_err) begin
                  state_d = StErr1;
               end else if (WAIT_STATES == 0) begin
                  state_d = StData;
               end else begin
                  state_d = StWait;
                  cnt_d   = WaitLoad;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (cnt_q == 3'd0) state_d = StData;
            else               cnt_d   = cnt_q - 3'd1;
         end
         StErr1:  state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.hreadyout = 1'b1;
      bus.hresp     = 1'b0;
      bus.hrdata    = 32'h0;
      unique case (state_q)
         StWait: bus.hreadyout = 1'b0;
         StData: if (!write_q) bus.hrdata = mem[addr_q];
         StErr1: begin
            bus.hreadyout = 1'b0;
            bus.hresp     = 1'b1;
         end
         StErr2:  bus.hresp = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      lane_en = 4'b1111;
      case (size_q)
         3'b000:  lane_en = 4'b0001 << off_q;
         3'b001:  lane_en = off_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   // Reset clears state_q asynchronously, so an aborted write never reaches this edge.
   assign commit = (state_q == StData) && write_q && !err_q;

   always_ff @(posedge hclk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) mem[addr_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahb_ram_responder.sv
// Scoreboard bench: three responders (0, 2 and 3 wait states) share one master driver;
// a byte-level reference model predicts each response and a monitor checks it.
module tb_ahb_ram_responder;

   typedef struct {
      bit          err;
      bit          rd;
      logic [31:0] data;
      int          waits;
   } exp_t;

   localparam time TLimit = 64'd600000;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        m_hsel;
   logic [31:0] m_haddr;
   logic [1:0]  m_htrans;
   logic        m_hwrite;
   logic [2:0]  m_hsize;
   logic [3:0]  m_hprot;
   logic [31:0] m_hwdata;
   int          cur;

   logic [2:0]  rdy_v;
   logic [2:0]  resp_v;
   logic [31:0] rdata_v [3];

   exp_t        sb [$];
   logic [7:0]  mm [int];
   int          n_tests = 0;
   int          n_fail = 0;
   bit          done = 1'b0;

   always #5 hclk = ~hclk;

   ahb_ram_responder_if bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign bus[g].hsel   = m_hsel && (cur == g);
      assign bus[g].haddr  = m_haddr;
      assign bus[g].htrans = m_htrans;
      assign bus[g].hwrite = m_hwrite;
      assign bus[g].hsize  = m_hsize;
      assign bus[g].hprot  = m_hprot;
      assign bus[g].hwdata = m_hwdata;
      assign bus[g].hready = bus[g].hreadyout;
      assign rdy_v[g]      = bus[g].hreadyout;
      assign resp_v[g]     = bus[g].hresp;
      assign rdata_v[g]    = bus[g].hrdata;

      ahb_ram_responder #(
         .ADDR_WIDTH  (10),
         .BASE        (8'hB0),
         .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
      ) dut (
         .hclk   (hclk),
         .hreset (hreset),
         .bus    (bus[g])
      );
   end

   function automatic int ws(int c);
      return (c == 0) ? 0 : ((c == 1) ? 2 : 3);
   endfunction

   function automatic int key(int c, logic [31:0] a);
      return c * 65536 + int'(a[15:0]);
   endfunction

   // Legal: inside the 4 KB window at 0xB0xx_xxxx, size up to a word, naturally aligned.
   function automatic bit model_err(logic [31:0] a, logic [2:0] sz);
      if (a[31:24] != 8'hB0) return 1'b1;
      if (a[23:0] >= 24'd4096) return 1'b1;
      if (sz > 3'd2) return 1'b1;
      if ((a % (32'd1 << sz)) != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic xfer(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                       input logic [31:0] wd);
      exp_t e;
      m_hsel   = 1'b1;
      m_htrans = ($urandom_range(1) == 1) ? 2'b10 : 2'b11;
      m_haddr  = a;
      m_hwrite = wr;
      m_hsize  = sz;
      m_hprot  = 4'($urandom);
      while (!rdy_v[cur]) begin
         @(posedge hclk);
         #1;
      end
      @(posedge hclk);
      #1;
      m_hwdata = wd;
      m_hsel   = 1'b0;
      m_htrans = 2'b00;
      e.err   = model_err(a, sz);
      e.rd    = !wr;
      e.waits = e.err ? 1 : ws(cur);
      e.data  = 32'h0;
      if (!e.err) begin
         if (wr) begin
            for (int i = 0; i < (1 << sz); i++) begin
               logic [31:0] b;
               b = a + 32'(i);
               mm[key(cur, b)] = wd[8*b[1:0] +: 8];
            end
         end else begin
            for (int j = 0; j < 4; j++) e.data[8*j +: 8] = mm[key(cur, {a[31:2], 2'b00}) + j];
         end
      end
      sb.push_back(e);
   endtask

   task automatic idle_bus();
      m_hsel   = 1'b0;
      m_htrans = 2'b00;
      while (!rdy_v[cur]) begin
         @(posedge hclk);
         #1;
      end
      @(posedge hclk);
      #1;
   endtask

   task automatic gap();
      m_hsel   = 1'($urandom_range(1));
      m_htrans = 2'($urandom_range(1));
      @(posedge hclk);
      #1;
   endtask

   task automatic rand_xfer();
      logic [31:0] a;
      logic [2:0]  sz;
      int          kind;
      kind = $urandom_range(9);
      sz   = 3'($urandom_range(2));
      a    = 32'hB000_0000 + 32'(4 * $urandom_range(15))
             + 32'(($urandom_range(3)) & ~((1 << sz) - 1));
      if (kind == 7) begin
         a[31:24] = 8'($urandom);
         if (a[31:24] == 8'hB0) a[31:24] = 8'hC0;
      end else if (kind == 8) begin
         a = a | (32'($urandom_range(1, 4095)) << 12);
      end else if (kind == 9) begin
         if ($urandom_range(1) == 1) begin
            sz = 3'($urandom_range(3, 7));
         end else begin
            sz = 3'($urandom_range(1, 2));
            a[1:0] = (sz == 3'd1) ? 2'b01 : 2'($urandom_range(1, 3));
         end
      end
      xfer(a, 1'($urandom_range(1)), sz, $urandom);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cur=%0d, t=%0t)", name, act, exp, cur, $time);
      end
   endtask

   // Driver
   initial begin
      m_hsel = 1'b0; m_haddr = 32'h0; m_htrans = 2'b00; m_hwrite = 1'b0;
      m_hsize = 3'b000; m_hprot = 4'h0; m_hwdata = 32'h0; cur = 0;
      repeat (2) @(posedge hclk);
      #1 hreset = 1'b0;

      for (int c = 0; c < 3; c++) begin
         cur = c;
         for (int w = 0; w < 16; w++) xfer(32'hB000_0000 + 32'(4 * w), 1'b1, 3'd2, $urandom);
         idle_bus();
      end

      cur = 0;
      xfer(32'hB000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF);
      xfer(32'hB000_0010, 1'b0, 3'd2, 32'h0);
      idle_bus();
      xfer(32'hB000_0010, 1'b1, 3'd2, 32'h0);
      xfer(32'hB000_0013, 1'b1, 3'd0, {8'h5A, 24'($urandom)});
      xfer(32'hB000_0010, 1'b1, 3'd1, {16'($urandom), 16'h1234});
      xfer(32'hB000_0010, 1'b0, 3'd2, 32'h0);
      idle_bus();
      xfer(32'hB000_0020, 1'b1, 3'd2, $urandom);
      xfer(32'hB000_0020, 1'b0, 3'd2, 32'h0);
      xfer(32'hB000_0024, 1'b0, 3'd2, 32'h0);
      idle_bus();
      xfer(32'hB000_0002, 1'b0, 3'd2, 32'h0);
      xfer(32'hC000_0000, 1'b1, 3'd0, $urandom);
      xfer(32'hB000_0010, 1'b0, 3'd2, 32'h0);
      idle_bus();

      cur = 2;
      xfer(32'hB000_0010, 1'b0, 3'd2, 32'h0);
      xfer(32'hB000_0002, 1'b0, 3'd2, 32'h0);
      xfer(32'hB000_0014, 1'b0, 3'd2, 32'h0);
      idle_bus();

      // Reset lands in the first WAIT cycle of a write; the word must keep its old value.
      cur = 1;
      m_hsel = 1'b1; m_htrans = 2'b10; m_haddr = 32'hB000_0014; m_hwrite = 1'b1;
      m_hsize = 3'd2;
      @(posedge hclk);
      #1;
      m_hsel = 1'b0; m_htrans = 2'b00; m_hwdata = 32'h0BAD_F00D;
      #1 hreset = 1'b1;
      @(posedge hclk);
      #1 hreset = 1'b0;
      xfer(32'hB000_0014, 1'b0, 3'd2, 32'h0);
      idle_bus();

      for (int r = 0; r < 6; r++) begin
         cur = r % 3;
         for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3) == 0) gap();
            rand_xfer();
         end
         idle_bus();
      end
      done = 1'b1;
   end

   // Monitor
   initial begin : mon
      bit   pending;
      int   waits;
      exp_t e;
      pending = 1'b0;
      waits   = 0;
      forever begin
         @(negedge hclk or posedge hreset);
         if (hreset) begin
            #1;
            chk("reset_hreadyout", 32'(rdy_v[cur]), 32'd1);
            chk("reset_hresp", 32'(resp_v[cur]), 32'd0);
            chk("reset_hrdata", rdata_v[cur], 32'h0);
            pending = 1'b0;
         end else begin
            if ($time > TLimit) begin
               chk("timeout", 32'd1, 32'd0);
               $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
               $finish;
            end
            if (pending) begin
               if (sb.size() == 0) begin
                  chk("unexpected_data_phase", 32'd1, 32'd0);
                  pending = 1'b0;
               end else if (!rdy_v[cur]) begin
                  waits++;
                  chk("wait_hresp", 32'(resp_v[cur]), 32'(sb[0].err));
                  chk("wait_hrdata", rdata_v[cur], 32'h0);
               end else begin
                  e = sb.pop_front();
                  chk("done_hresp", 32'(resp_v[cur]), 32'(e.err));
                  chk("wait_count", 32'(waits), 32'(e.waits));
                  if (e.err)     chk("err_hrdata", rdata_v[cur], 32'h0);
                  else if (e.rd) chk("read_data", rdata_v[cur], e.data);
                  pending = 1'b0;
               end
            end else begin
               chk("idle_hreadyout", 32'(rdy_v[cur]), 32'd1);
               chk("idle_hresp", 32'(resp_v[cur]), 32'd0);
               chk("idle_hrdata", rdata_v[cur], 32'h0);
            end
            if (rdy_v[cur] && m_hsel && m_htrans[1]) begin
               pending = 1'b1;
               waits   = 0;
            end
            if (done && !pending) begin
               chk("sb_drained", 32'(sb.size()), 32'd0);
               $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
               $finish;
            end
         end
      end
   end

endmodule

// File: doc/ahb_ram_responder.md
Name: ahb_ram_responder

Overview:
- AHB-Lite responder (slave) for the data RAM region (haddr[31:24] == 8'hB0). It is the far end of the core's AHB master glue.
- Captures address-phase controls and completes the data phase with a programmable number of wait states.
- Performs byte, halfword and word writes using little-endian byte lanes. Returns full-word read data.
- Signals ERROR for illegal accesses using the standard two-cycle response.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words (default 4 KB).
- BASE, 8'hB0, required value of haddr[31:24].
- WAIT_STATES, 0, wait cycles (hreadyout=0) inserted per OKAY transfer; 0..7.

Ports:
- hclk, input, 1, bus clock; all state changes on the rising edge.
- hreset, input, 1, asynchronous active-high reset.
- hsel, input, 1, slave select from the decoder.
- haddr, input, 32, byte address.
- htrans, input, 2, 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite, input, 1, 1 = write.
- hsize, input, 3, 000 byte, 001 halfword, 010 word.
- hprot, input, 4, accepted and ignored.
- hwdata, input, 32, write data, valid in the data phase.
- hready, input, 1, global ready; an address phase is sampled only when it is 1.
- hreadyout, output, 1, this slave's ready.
- hresp, output, 1, 0 OKAY, 1 ERROR.
- hrdata, output, 32, read data.

Behaviour:
- Clock and reset: one clock, hclk. Reset hreset is asynchronous, active-high.
- Reset values: state=IDLE, hreadyout=1, hresp=0, hrdata=0, all latched address-phase registers cleared.
- RAM contents are not reset.
- Reset asserted mid-transfer aborts the transfer. A pending write is dropped, with no partial lane update.
- Address-phase capture happens at a rising edge when hsel & hready & htrans[1] are all 1.
  - Latched: word address haddr[ADDR_WIDTH+1:2], byte offset haddr[1:0], hsize, hwrite.
  - Also latched: an error flag.
- The error flag is set for any of:
  - haddr[31:24] != BASE;
  - haddr[23:ADDR_WIDTH+2] != 0;
  - hsize > 3'b010;
  - a halfword with haddr[0]=1;
  - a word with haddr[1:0] != 0.
- htrans IDLE or BUSY, or hsel=0, produces no capture; the next cycle is IDLE (zero-wait OKAY).
- SEQ is handled identically to NONSEQ.
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
  - WAIT: hreadyout=0, hresp=0. A down-counter loaded with WAIT_STATES-1; exits to DATA when it reaches 0.
  - DATA: hreadyout=1, hresp=0. The transfer completes at the end of this cycle.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- Transitions on capture, from any of IDLE, DATA or ERR2:
  - error flag set -> ERR1;
  - otherwise WAIT_STATES==0 -> DATA;
  - otherwise -> WAIT.
- ERR1 always goes to ERR2.
- DATA or ERR2 with no capture goes to IDLE.
- Back-to-back pipelined transfers from DATA->DATA are supported at one transfer per cycle when WAIT_STATES=0.
- No capture is possible in WAIT or ERR1, because hready is low in those cycles.
- Writes commit to RAM at the rising edge that ends DATA, using hwdata as sampled on that edge.
- Byte-lane enables for writes:
  - byte: lane haddr[1:0];
  - halfword: lanes {haddr[1],0} and {haddr[1],1};
  - word: all four lanes.
- Lane n maps to hwdata[8n+7:8n] and is stored to the same lane. Unselected lanes are unchanged.
- Reads: hrdata = RAM[latched word address], full 32 bits, during DATA of a read. Sign/zero extension and lane extraction are the master's job.
- hrdata = 0 in every other state.
- The RAM read is asynchronous on the latched address, so a read directly following a write to the same word returns the new data.
- ERROR transfers never modify RAM; hrdata=0.

Test Plan:
- Reset defaults: hreset pulse mid-WAIT with WAIT_STATES=2 -> hreadyout=1, hresp=0 and hrdata=0 immediately; the target word is unchanged.
- Word write then read: write NONSEQ to B000_0010 with hwdata=DEADBEEF, then read B000_0010 -> hrdata=DEADBEEF, hresp=0, zero waits.
- Byte lanes: with word 0x10 holding 0, write byte 0x5A to B000_0013, then halfword 0x1234 to B000_0010 -> a read returns 5A00_1234.
- Pipelining with WAIT_STATES=0: write A, read A, read B in consecutive cycles -> three DATA cycles with no bubbles, and the read of A returns the freshly written value.
- Wait states with WAIT_STATES=3: a read -> exactly 3 cycles of hreadyout=0, then 1 DATA cycle with valid hrdata.
- Errors: word read at B000_0002, and a byte write to C000_0000 -> each gives hreadyout=0,hresp=1 then hreadyout=1,hresp=1. RAM is unmodified, and the next OKAY transfer succeeds.
